serial_word_feeder: RTL and testbench

//  Upstream stage for the serial two's-complement inverter (bit-serial, LSB-first, per-word clear).
//  - Accepts parallel words over a valid/ready handshake.
//  - Serialises each word LSB-first, one bit per t_clk.
//  - Drives the inverter's per-word clear (ser_rst) so every word starts from a cleared state.
//  - Keeps a wrapping count of completed words for debug/bench use.

---
 rtl/serial_word_feeder_pkg.sv | 13 +
 rtl/serial_word_feeder_bit_counter.sv | 36 +++
 rtl/serial_word_feeder.sv | 129 ++++++++++++
 tb/tb_serial_word_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder and its downstream peers.
// State encodings match the deserializer's view of the link.
package serial_word_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int unsigned WS_W = 16;

endpackage

// File: rtl/serial_word_feeder_bit_counter.sv
// Up-counter with synchronous clear and a terminal-value flag.
// Used for both the bit index and the pre-word clear gap.
module serial_bit_counter #(
  parameter int W    = 3,
  parameter int TERM = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == W'(TERM));

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the bit-serial two's-complement inverter.
// Each word is preceded by GAP clear cycles and shifted out LSB first.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1,
  parameter int CNT_W = WS_W
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_bit,
  output logic             ser_rst,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = $clog2(GAP + 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CNT_W-1:0] ws_q;
  logic [CNT_W-1:0] ws_d;

  logic [BW-1:0] bitcnt;
  logic [GW-1:0] gapcnt;
  logic          bit_last;
  logic          gap_last;
  logic          xfer;
  logic          unused_gapcnt;

  assign xfer          = din_valid && din_ready;
  assign unused_gapcnt = ^gapcnt;

  serial_bit_counter #(
    .W    (BW),
    .TERM (WIDTH - 1)
  ) u_bitcnt (
    .clk_i  (t_clk),
    .rst_i  (r),
    .clr_i  (state_q == ST_CLEAR && gap_last),
    .inc_i  (state_q == ST_SHIFT),
    .cnt_o  (bitcnt),
    .term_o (bit_last)
  );

  serial_bit_counter #(
    .W    (GW),
    .TERM (GAP - 1)
  ) u_gapcnt (
    .clk_i  (t_clk),
    .rst_i  (r),
    .clr_i  (xfer),
    .inc_i  (state_q == ST_CLEAR),
    .cnt_o  (gapcnt),
    .term_o (gap_last)
  );

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      ws_q    <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ws_q    <= ws_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (xfer) state_d = ST_CLEAR;
      ST_CLEAR:
        if (gap_last) state_d = ST_SHIFT;
      ST_SHIFT:
        if (bit_last)
          state_d = xfer ? ST_CLEAR : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // A load on the last-bit edge wins over the shift.
  always_comb begin
    shreg_d = shreg_q;
    ws_d    = ws_q;
    if (xfer)
      shreg_d = din;
    else if (state_q == ST_SHIFT)
      shreg_d = shreg_q >> 1;
    if (state_q == ST_SHIFT && bit_last)
      ws_d = ws_q + 1'b1;
  end

  always_comb begin
    din_ready = 1'b0;
    ser_bit   = 1'b0;
    ser_rst   = 1'b1;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:
        din_ready = 1'b1;
      ST_SHIFT: begin
        ser_rst   = 1'b0;
        ser_bit   = shreg_q[0];
        ser_first = (bitcnt == '0);
        ser_last  = bit_last;
        din_ready = bit_last;
      end
      default: ;
    endcase
  end

  assign words_sent = ws_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder with a serial negator model.
// A narrow-counter twin instance exercises the words_sent wrap.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic        t_clk = 1'b0;
  logic        r = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, ser_bit, ser_rst;
  logic        ser_first, ser_last, busy;
  logic [15:0] words_sent;
  logic        s_ready, s_bit, s_rst;
  logic        s_first, s_last, s_busy;
  logic [2:0]  s_ws;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_q[$];
  int          bitn = 0;
  int          low_run = 0;
  int          hi_run = 0;
  int          last_gap = 0;
  logic [15:0] ws_m = '0;
  logic [7:0]  got = '0;
  logic [7:0]  goty = '0;
  logic [7:0]  e = '0;
  logic        seen1 = 1'b0;

  always #82 t_clk = ~t_clk;

  serial_word_feeder #(.WIDTH(W), .GAP(1)) dut (
    .t_clk      (t_clk),
    .r          (r),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ser_bit    (ser_bit),
    .ser_rst    (ser_rst),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .busy       (busy),
    .words_sent (words_sent)
  );

  serial_word_feeder #(.WIDTH(W), .GAP(1), .CNT_W(3)) twin (
    .t_clk      (t_clk),
    .r          (r),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (s_ready),
    .ser_bit    (s_bit),
    .ser_rst    (s_rst),
    .ser_first  (s_first),
    .ser_last   (s_last),
    .busy       (s_busy),
    .words_sent (s_ws)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge t_clk)
    if (!r && din_valid && din_ready)
      exp_q.push_back(din);

  always @(negedge t_clk) begin
    if (r) begin
      bitn = 0;
      low_run = 0;
      hi_run = 0;
      ws_m = '0;
      seen1 = 1'b0;
      exp_q.delete();
    end else begin
      chk("ws", 32'(words_sent), 32'(ws_m));
      chk("ws_small", 32'(s_ws), 32'(ws_m[2:0]));
      chk("twin",
          {26'd0, s_ready, s_bit, s_rst, s_first, s_last, s_busy},
          {26'd0, din_ready, ser_bit, ser_rst, ser_first, ser_last, busy});
      if (!ser_rst) begin
        if (hi_run != 0) last_gap = hi_run;
        hi_run = 0;
        low_run++;
        chk("first", 32'(ser_first), 32'(bitn == 0));
        chk("last", 32'(ser_last), 32'(bitn == W - 1));
        got[bitn]  = ser_bit;
        goty[bitn] = seen1 ? ~ser_bit : ser_bit;
        seen1 = seen1 | ser_bit;
        if (bitn == W - 1) begin
          chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word", 32'(got), 32'(e));
            chk("inv_y", 32'(goty), 32'(8'(~e + 8'd1)));
          end
          ws_m++;
          bitn = 0;
          seen1 = 1'b0;
        end else begin
          bitn++;
        end
      end else begin
        chk("bit_in_rst", 32'(ser_bit), 32'd0);
        chk("rst_midword", 32'(bitn), 32'd0);
        if (low_run != 0) chk("low_run", 32'(low_run), 32'(W));
        low_run = 0;
        hi_run++;
      end
    end
  end

  task automatic send(input logic [7:0] w, output int n);
    din = w;
    din_valid = 1'b1;
    n = 0;
    do begin
      @(posedge t_clk);
      n++;
    end while (!din_ready && n < 40);
    chk("accept", 32'(din_ready), 32'd1);
    @(negedge t_clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge t_clk);
      n++;
    end
    chk("idle_to", 32'(busy), 32'd0);
    @(negedge t_clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    #30;
    chk("rst_ser_rst", 32'(ser_rst), 32'd1);
    chk("rst_ser_bit", 32'(ser_bit), 32'd0);
    chk("rst_first", 32'(ser_first), 32'd0);
    chk("rst_last", 32'(ser_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(din_ready), 32'd1);
    chk("rst_ws", 32'(words_sent), 32'd0);
    @(negedge t_clk);
    #10 r = 1'b0;

    repeat (5) begin
      @(negedge t_clk);
      chk("stall_ready", 32'(din_ready), 32'd1);
      chk("stall_busy", 32'(busy), 32'd0);
      chk("stall_rst", 32'(ser_rst), 32'd1);
      chk("stall_bit", 32'(ser_bit), 32'd0);
    end

    send(8'h06, n);
    din_valid = 1'b0;
    chk("t1_clear", 32'(ser_rst), 32'd1);
    @(negedge t_clk);
    chk("t1_first", 32'(ser_first), 32'd1);
    wait_idle();
    chk("t1_ws", 32'(words_sent), 32'd1);

    send(8'h01, n);
    send(8'h80, n);
    din_valid = 1'b0;
    chk("t2_b2b_edges", 32'(n), 32'(W + 1));
    wait_idle();
    chk("t2_gap", 32'(last_gap), 32'd1);
    chk("t2_ws", 32'(words_sent), 32'd3);

    send(8'h00, n);
    din_valid = 1'b0;
    wait_idle();
    chk("t3_ws", 32'(words_sent), 32'd4);

    send(8'h5A, n);
    din_valid = 1'b0;
    repeat (4) @(posedge t_clk);
    #20 r = 1'b1;
    #1;
    chk("t4_ser_rst", 32'(ser_rst), 32'd1);
    chk("t4_ser_bit", 32'(ser_bit), 32'd0);
    chk("t4_first", 32'(ser_first), 32'd0);
    chk("t4_last", 32'(ser_last), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(din_ready), 32'd1);
    chk("t4_ws", 32'(words_sent), 32'd0);
    @(negedge t_clk);
    @(negedge t_clk);
    #10 r = 1'b0;
    @(negedge t_clk);
    send(8'h03, n);
    din_valid = 1'b0;
    wait_idle();
    chk("t4_ws_after", 32'(words_sent), 32'd1);

    for (int i = 0; i < 7; i++)
      send(8'($urandom_range(0, 255)), n);
    din_valid = 1'b0;
    wait_idle();
    chk("t5_ws", 32'(words_sent), 32'd8);
    chk("t5_wrap", 32'(s_ws), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
